// File: rtl/mem_char_display_pkg.sv
// Shared types and the ASCII-to-7-segment decoder for the memory character display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package mem_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Lower-case letters fold onto upper case; letters with no readable glyph show a dash.
  function automatic logic [6:0] char_to_seg(input logic [7:0] ch);
    logic [7:0] c;
    char_to_seg = SEG_DASH;
    c = ch;
    if (ch >= 8'h61 && ch <= 8'h7A) c = ch - 8'h20;
    case (c)
      8'h20: char_to_seg = SEG_BLANK;
      8'h30: char_to_seg = 7'h40;
      8'h31: char_to_seg = 7'h79;
      8'h32: char_to_seg = 7'h24;
      8'h33: char_to_seg = 7'h30;
      8'h34: char_to_seg = 7'h19;
      8'h35: char_to_seg = 7'h12;
      8'h36: char_to_seg = 7'h02;
      8'h37: char_to_seg = 7'h78;
      8'h38: char_to_seg = 7'h00;
      8'h39: char_to_seg = 7'h10;
      8'h41: char_to_seg = 7'h08;
      8'h42: char_to_seg = 7'h03;
      8'h43: char_to_seg = 7'h46;
      8'h44: char_to_seg = 7'h21;
      8'h45: char_to_seg = 7'h06;
      8'h46: char_to_seg = 7'h0E;
      8'h47: char_to_seg = 7'h42;
      8'h48: char_to_seg = 7'h09;
      8'h49: char_to_seg = 7'h79;
      8'h4A: char_to_seg = 7'h61;
      8'h4C: char_to_seg = 7'h47;
      8'h4E: char_to_seg = 7'h2B;
      8'h4F: char_to_seg = 7'h23;
      8'h50: char_to_seg = 7'h0C;
      8'h51: char_to_seg = 7'h18;
      8'h52: char_to_seg = 7'h2F;
      8'h53: char_to_seg = 7'h12;
      8'h54: char_to_seg = 7'h07;
      8'h55: char_to_seg = 7'h41;
      8'h59: char_to_seg = 7'h11;
      8'h5A: char_to_seg = 7'h24;
      default: char_to_seg = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/mem_char_display_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debouncer and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int CYC = 500000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_step,
  output logic o_level
);

  localparam int CNT_W = (CYC > 2) ? $clog2(CYC) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Accept the new level on the CYC-th consecutive differing sample.
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_W'(CYC - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_step  = r_level & ~r_level_d;
  assign o_level = r_level;

endmodule

// File: rtl/mem_char_display.sv
// Steps through a window of data memory on each button press and shows the low
// byte of the fetched word as a character on one 7-segment digit.
module mem_char_display
  import mem_disp_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 8'h00,
  parameter int                NUM_WORDS    = 16,
  parameter int                DEBOUNCE_CYC = 500000,
  parameter int                RD_LAT       = 1,
  localparam int               IDX_W        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_next,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [IDX_W-1:0]  cur_index,
  output logic              busy,
  output logic [6:0]        segments,
  output logic [1:0]        dbg_state
);

  // READ lasts RD_LAT cycles, but never less than one.
  localparam logic [1:0] WAIT_LAST = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  logic              w_step;
  logic              w_level_unused;
  logic              w_rdata_unused;
  logic [IDX_W-1:0]  w_next_index;
  state_t            r_state;
  logic [IDX_W-1:0]  r_index;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_wait;
  logic [6:0]        r_seg;
  logic              r_busy;

  btn_debounce #(
    .CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .i_clk   (clk),
    .i_reset (reset),
    .i_btn   (btn_next),
    .o_step  (w_step),
    .o_level (w_level_unused)
  );

  assign w_next_index   = (r_index == IDX_W'(NUM_WORDS - 1)) ? '0 : r_index + IDX_W'(1);
  assign w_rdata_unused = ^mem_rdata[DATA_W-1:8];

  // Address only moves on the IDLE->READ transition, so it is stable for the whole read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= READ;
      r_index <= '0;
      r_addr  <= BASE_ADDR;
      r_wait  <= '0;
      r_seg   <= SEG_BLANK;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_step) begin
            r_index <= w_next_index;
            r_addr  <= BASE_ADDR + ADDR_W'(w_next_index);
            r_wait  <= '0;
            r_busy  <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          if (r_wait == WAIT_LAST) r_state <= LATCH;
          else                     r_wait  <= r_wait + 2'd1;
        end
        LATCH: begin
          r_seg   <= char_to_seg(mem_rdata[7:0]);
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign cur_index = r_index;
  assign busy      = r_busy;
  assign segments  = r_seg;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_char_display.sv
// Directed bench for mem_char_display with a registered one-cycle-latency memory model.
module tb_mem_char_display;

  logic        clk;
  logic        reset;
  logic        btn_next;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [1:0]  cur_index;
  logic        busy;
  logic [6:0]  segments;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  mem_char_display #(
    .ADDR_W       (8),
    .DATA_W       (32),
    .BASE_ADDR    (8'h10),
    .NUM_WORDS    (4),
    .DEBOUNCE_CYC (4),
    .RD_LAT       (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_next  (btn_next),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .cur_index (cur_index),
    .busy      (busy),
    .segments  (segments),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Press and hold until the read starts, check the display pipeline, then release.
  task automatic press(input string tag, input logic [1:0] exp_idx, input logic [7:0] exp_addr,
                       input logic [6:0] old_seg, input logic [6:0] exp_seg);
    int seen;
    seen = 0;
    btn_next = 1'b1;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      cyc(1);
      if (busy === 1'b1) seen = 1;
    end
    chk({tag, "_busy_seen"}, 32'(seen), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    chk({tag, "_index"}, 32'(cur_index), 32'(exp_idx));
    chk({tag, "_seg_hold0"}, 32'(segments), 32'(old_seg));
    cyc(1);
    chk({tag, "_seg_hold1"}, 32'(segments), 32'(old_seg));
    cyc(1);
    chk({tag, "_seg_new"}, 32'(segments), 32'(exp_seg));
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    btn_next = 1'b0;
    cyc(12);
    chk({tag, "_addr_stable"}, 32'(mem_addr), 32'(exp_addr));
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h0000_0041;
    mem[8'h11] = 32'hFFFF_FF31;
    mem[8'h12] = 32'h0000_0065;
    mem[8'h13] = 32'h0000_0020;
    reset    = 1'b1;
    btn_next = 1'b0;

    // Reset state, then the first word loads by itself.
    cyc(3);
    chk("rst_addr", 32'(mem_addr), 32'h10);
    chk("rst_seg", 32'(segments), 32'h7F);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_index", 32'(cur_index), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd1);
    reset = 1'b0;
    cyc(1);
    chk("boot_seg_e1", 32'(segments), 32'h7F);
    cyc(1);
    chk("boot_seg_e2", 32'(segments), 32'h08);
    chk("boot_busy_e2", 32'(busy), 32'd0);
    cyc(1);
    chk("boot_seg_e3", 32'(segments), 32'h08);
    chk("boot_state_idle", 32'(dbg_state), 32'd0);

    // A 3-cycle bounce is shorter than the debounce window: no step.
    btn_next = 1'b1;
    cyc(3);
    btn_next = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (busy === 1'b1) seen = 1;
    end
    chk("glitch_no_step", 32'(seen), 32'd0);
    chk("glitch_addr", 32'(mem_addr), 32'h10);
    chk("glitch_index", 32'(cur_index), 32'd0);

    // Walk the window, including the wrap back to index 0.
    press("p1", 2'd1, 8'h11, 7'h08, 7'h79);
    press("p2", 2'd2, 8'h12, 7'h79, 7'h06);
    press("p3", 2'd3, 8'h13, 7'h06, 7'h7F);
    press("p4_wrap", 2'd0, 8'h10, 7'h7F, 7'h08);
    mem[8'h11] = 32'h0000_004B;
    press("p5_k", 2'd1, 8'h11, 7'h08, 7'h3F);
    mem[8'h12] = 32'h1234_5638;
    press("p6_8", 2'd2, 8'h12, 7'h3F, 7'h00);
    mem[8'h13] = 32'h0000_0030;
    press("p7_0", 2'd3, 8'h13, 7'h00, 7'h40);

    // Reset lands while the next read is in flight.
    btn_next = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      cyc(1);
      if (busy === 1'b1) seen = 1;
    end
    chk("mid_busy_seen", 32'(seen), 32'd1);
    chk("mid_seg_before", 32'(segments), 32'h40);
    reset    = 1'b1;
    btn_next = 1'b0;
    cyc(1);
    chk("mid_rst_seg", 32'(segments), 32'h7F);
    chk("mid_rst_addr", 32'(mem_addr), 32'h10);
    chk("mid_rst_index", 32'(cur_index), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    cyc(1);
    chk("mid_boot_e1", 32'(segments), 32'h7F);
    cyc(1);
    chk("mid_boot_e2", 32'(segments), 32'h08);
    chk("mid_boot_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
